// File: rtl/osmanip_mem_master.sv
// osmanip_mem_master: Avalon-MM master block-transfer engine for the on-chip RAM.
//
// Accepts one command at a time. A write command streams wr_data words into
// consecutive RAM addresses. A read command streams consecutive RAM words out on
// rd_data through a small return FIFO. Addresses wrap modulo 2^ADDR_W.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   cmd_*             command handshake (valid/ready, direction, start address, length)
//   busy, done        busy from the cycle after accept through done; done is a 1-cycle pulse
//   wr_data/valid/ready   input stream (stream-to-RAM)
//   rd_data/valid/ready   output stream (RAM-to-stream)
//   address, byteenable, chipselect, write, writedata, readdata, clken
//                     Avalon-MM master to a slave with fixed read latency 1
module osmanip_mem_master #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [ADDR_W:0]       cmd_len,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W-1:0]     readdata,
    output logic                  clken
);

    localparam int unsigned LenW = ADDR_W + 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [LenW-1:0]   remaining_q;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   occupancy;

    logic accept, wr_fire, rd_issue, push, pop, last_word, drained;

    assign accept    = cmd_valid && (state_q == StIdle);
    assign wr_fire   = (state_q == StWrite) && wr_valid;
    // Outstanding read plus stored words must leave room for the new return word.
    assign occupancy = count_q + CntW'(inflight_q);
    assign rd_issue  = (state_q == StRead) && (occupancy < CntW'(FIFO_DEPTH));
    assign push      = inflight_q;
    assign rd_valid  = (count_q != '0);
    assign rd_data   = fifo_q[rptr_q];
    assign pop       = rd_valid && rd_ready;
    assign last_word = (remaining_q == LenW'(1));
    // Drain ends once nothing is in flight and the final word leaves this cycle.
    assign drained   = !inflight_q &&
                       ((count_q == '0) || ((count_q == CntW'(1)) && pop));

    assign byteenable = '1;
    assign clken      = 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        state_d = StDone;
                    end else if (cmd_write) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: if (wr_fire && last_word) state_d = StDone;
            StRead:  if (rd_issue && last_word) state_d = StDrain;
            StDrain: if (drained) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        wr_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            StWrite: wr_ready = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
        chipselect = wr_fire || rd_issue;
        write      = wr_fire;
        address    = addr_q;
        writedata  = wr_fire ? wr_data : '0;
    end

    // Address / length bookkeeping and read-latency tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            if (accept) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LenW'(1);
            end
        end
    end

    // Read-return FIFO pointers and fill count
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since count_q gates visibility
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= readdata;
    end

endmodule

// File: tb/tb_osmanip_mem_master.sv
module tb_osmanip_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic        busy, done;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect, write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        clken;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stray  = 0;

    logic [31:0] ram     [1024];
    logic [31:0] exp_mem [1024];

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [10:0] len;
        logic [31:0] base;
        bit          gaps;
        int          stall;
        int          exp_acc;
        logic [9:0]  exp_last_addr;
        logic [31:0] exp_last_data;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          c;
    } ev_t;

    osmanip_mem_master #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .busy       (busy),
        .done       (done),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .clken      (clken)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // On-chip RAM slave model: read latency 1, preloaded with addr==data.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'(i);
        end else begin
            if (chipselect && write) ram[address] <= writedata;
            if (chipselect && !write) readdata <= ram[address];
        end
    end

    // Avalon access outside a command is never allowed.
    always @(negedge clk) begin
        if (!reset && chipselect && !busy) stray <= stray + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issues one command and monitors it until done. Entered and left #1 after a posedge.
    task automatic run_cmd(input vec_t v);
        ev_t wq[$];
        ev_t iq[$];
        ev_t pq[$];
        ev_t e;
        int acc_cyc, done_cyc, done_cnt, k, budget, out, max_out, pre_stall, n, exp_done;
        bit wr_rdy_seen, ok, fire;
        logic [9:0]  a;
        logic [31:0] d;

        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        wr_valid  = 1'b0;
        rd_ready  = (v.stall == 0);
        @(negedge clk);
        check("cmd_ready before accept", cmd_ready, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        wr_valid    = v.wr;
        wr_data     = v.base;
        k           = 0;
        budget      = 0;
        done_cyc    = -1;
        done_cnt    = 0;
        out         = 0;
        max_out     = 0;
        pre_stall   = 0;
        wr_rdy_seen = 0;
        while (done_cnt == 0 && budget < 3000) begin
            @(negedge clk);
            fire = wr_valid && wr_ready;
            if (wr_ready) wr_rdy_seen = 1;
            if (chipselect) begin
                e.addr = address;
                e.data = writedata;
                e.c    = cyc;
                if (write) begin
                    wq.push_back(e);
                end else begin
                    iq.push_back(e);
                    out++;
                    if (!rd_ready) pre_stall++;
                end
            end
            if (rd_valid && rd_ready) begin
                e.addr = '0;
                e.data = rd_data;
                e.c    = cyc;
                pq.push_back(e);
                out--;
            end
            if (out > max_out) max_out = out;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy during done", busy, 1);
            end
            @(posedge clk);
            #1;
            budget++;
            if (fire) k++;
            wr_data = v.base + 32'(k);
            if (v.gaps) wr_valid = !wr_valid;
            if (budget >= v.stall) rd_ready = 1'b1;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("done pulse seen", done_cnt, 1);
        @(negedge clk);
        check("idle after done {cmd_ready,busy,done}", {cmd_ready, busy, done}, 3'b100);
        @(posedge clk);
        #1;

        n = v.exp_acc;
        if (v.wr) begin
            check("write strobe count", wq.size(), n);
            check("read issues on write cmd", iq.size(), 0);
        end else begin
            check("read issue count", iq.size(), n);
            check("read pop count", pq.size(), n);
            check("write strobes on read cmd", wq.size(), 0);
        end

        if (n > 0) begin
            // Access addresses must be consecutive modulo 1024.
            ok = 1;
            for (int i = 0; i < n; i++) begin
                a = v.addr + 10'(i);
                if (v.wr) begin
                    if (i >= wq.size() || wq[i].addr !== a) ok = 0;
                end else begin
                    if (i >= iq.size() || iq[i].addr !== a) ok = 0;
                end
            end
            check("address sequence", ok, 1);
            if (v.wr && wq.size() == n) check("last write address", wq[n-1].addr, v.exp_last_addr);
            if (!v.wr && iq.size() == n) check("last read address", iq[n-1].addr, v.exp_last_addr);

            // Data order against bench shadow memory.
            ok = 1;
            for (int i = 0; i < n; i++) begin
                a = v.addr + 10'(i);
                d = v.wr ? (v.base + 32'(i)) : exp_mem[a];
                if (v.wr) begin
                    if (i >= wq.size() || wq[i].data !== d) ok = 0;
                end else begin
                    if (i >= pq.size() || pq[i].data !== d) ok = 0;
                end
            end
            check("data sequence", ok, 1);
            if (v.wr && wq.size() == n) check("last write data", wq[n-1].data, v.exp_last_data);
            if (!v.wr && pq.size() == n) check("last read data", pq[n-1].data, v.exp_last_data);
        end

        if (v.wr) begin
            for (int i = 0; i < n; i++) begin
                a = v.addr + 10'(i);
                exp_mem[a] = v.base + 32'(i);
            end
        end

        if (n == 0) begin
            exp_done = acc_cyc + 1;
        end else if (v.wr) begin
            exp_done = (wq.size() > 0) ? wq[wq.size()-1].c + 1 : -2;
        end else begin
            exp_done = (pq.size() > 0) ? pq[pq.size()-1].c + 1 : -2;
        end
        check("done cycle", done_cyc, exp_done);

        if (v.wr && n > 0 && wq.size() == n) begin
            ok = 1;
            for (int i = 0; i < n; i++) begin
                if (wq[i].c != acc_cyc + 1 + (v.gaps ? 2 * i : i)) ok = 0;
            end
            check("write strobe cycles", ok, 1);
        end
        if (!v.wr && n > 0 && v.stall == 0 && iq.size() == n && pq.size() == n) begin
            check("first read issue cycle", iq[0].c, acc_cyc + 1);
            ok = 1;
            for (int i = 0; i < n; i++) begin
                if (pq[i].c != acc_cyc + 3 + i) ok = 0;
            end
            check("read pop cycles", ok, 1);
        end
        if (!v.wr || n == 0) check("wr_ready stays low", wr_rdy_seen, 0);
        if (!v.wr) check("outstanding reads within FIFO depth", (max_out <= 4), 1);
        if (!v.wr && v.stall > 0) check("issues during stall in 1..4",
                                        (pre_stall >= 1 && pre_stall <= 4), 1);
    endtask

    initial begin
        vec_t vecs [11];
        int   pops, dcnt, budget;

        // wr addr len base gaps stall exp_acc last_addr last_data
        vecs[0]  = '{1'b1, 10'h010, 11'd4,    32'hA0,   1'b0, 0,  4,    10'h013, 32'hA3};
        vecs[1]  = '{1'b0, 10'h010, 11'd4,    32'h0,    1'b0, 0,  4,    10'h013, 32'hA3};
        vecs[2]  = '{1'b0, 10'h3FE, 11'd4,    32'h0,    1'b0, 0,  4,    10'h001, 32'h001};
        vecs[3]  = '{1'b0, 10'h200, 11'd16,   32'h0,    1'b0, 10, 16,   10'h20F, 32'h20F};
        vecs[4]  = '{1'b1, 10'h020, 11'd0,    32'h77,   1'b0, 0,  0,    10'h000, 32'h0};
        vecs[5]  = '{1'b0, 10'h030, 11'd0,    32'h0,    1'b0, 0,  0,    10'h000, 32'h0};
        vecs[6]  = '{1'b1, 10'h050, 11'd3,    32'hC0,   1'b1, 0,  3,    10'h052, 32'hC2};
        vecs[7]  = '{1'b0, 10'h050, 11'd3,    32'h0,    1'b0, 0,  3,    10'h052, 32'hC2};
        vecs[8]  = '{1'b1, 10'h3FF, 11'd2,    32'h5000, 1'b0, 0,  2,    10'h000, 32'h5001};
        vecs[9]  = '{1'b0, 10'h3FF, 11'd2,    32'h0,    1'b0, 0,  2,    10'h000, 32'h5001};
        vecs[10] = '{1'b0, 10'h123, 11'd1024, 32'h0,    1'b0, 0,  1024, 10'h122, 32'h122};

        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'(i);

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = 32'hDEADBEEF;
        wr_valid  = 1'b1;
        rd_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cmd_ready", cmd_ready, 1);
        check("reset busy/done/wr_ready/rd_valid", {busy, done, wr_ready, rd_valid}, 4'b0000);
        check("reset chipselect/write", {chipselect, write}, 2'b00);
        check("reset address", address, 0);
        check("reset writedata", writedata, 0);
        check("reset byteenable/clken", {byteenable, clken}, 5'b11111);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wr_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

        // Reset in the middle of an 8-word read, after 3 words are delivered.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 10'h040;
        cmd_len   = 11'd8;
        rd_ready  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        pops      = 0;
        dcnt      = 0;
        budget    = 0;
        while (pops < 3 && budget < 100) begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                check("pre-reset read data", rd_data, exp_mem[10'h040 + 10'(pops)]);
                pops++;
            end
            if (done) dcnt++;
            budget++;
            if (pops < 3) begin
                @(posedge clk);
                #1;
            end
        end
        check("words before mid reset", pops, 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        if (done) dcnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("after reset rd_valid", rd_valid, 0);
        check("after reset cmd_ready/busy", {cmd_ready, busy}, 2'b10);
        check("after reset chipselect", chipselect, 0);
        if (done) dcnt++;
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("no done for aborted command", dcnt, 0);
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        run_cmd(vecs[1]);

        check("no access while idle", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
